// File: rtl/dac_stream_ctrl_if.sv
// rtl/dac_stream_ctrl_if.sv - upstream sample stream (valid/ready/data) for dac_stream_ctrl
interface dac_stream_ctrl_if #(
   parameter int W = 16
);
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dac_stream_ctrl.sv
// rtl/dac_stream_ctrl.sv - FIFO-buffered sample scheduler paced by the DAC core's val_req strobe
// Optional DAC_RAMP_EN adds RAMP_UP/RAMP_DN states that slew dac_val by RAMP_STEP per period.
module dac_stream_ctrl #(
   parameter int R2R_BITS  = 4,
   parameter int PWM_BITS  = 12,
   parameter int FIFO_AW   = 4,
   parameter int PRIME_LVL = 8,
   parameter int IDLE_VAL  = 0,
   parameter int RAMP_STEP = 256
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         enable,
   dac_stream_ctrl_if.slave             s,
   input  logic                         val_req,
   output logic [R2R_BITS+PWM_BITS-1:0] dac_val,
   output logic                         running,
   output logic                         underflow,
   output logic [15:0]                  underflow_cnt,
   output logic [FIFO_AW:0]             fifo_level
);
   localparam int W = R2R_BITS + PWM_BITS;
   localparam int D = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW+1)'(D);
   localparam logic [FIFO_AW:0] PRIME_L = (FIFO_AW+1)'(PRIME_LVL);
   localparam logic [W-1:0]     IDLE_W  = W'(IDLE_VAL);
   localparam logic [W-1:0]     STEP_W  = W'(RAMP_STEP);

   typedef enum logic [2:0] {IDLE, PRIME, RUN, STOP, RAMP_UP, RAMP_DN} state_t;
   state_t state;

   logic [W-1:0]     mem [D];
   logic [FIFO_AW:0] wptr, rptr, level;
   logic [W-1:0]     head;
   logic             rdy_q, full, empty, push;

   assign level      = wptr - rptr;
   assign fifo_level = level;
   assign full       = (level == DEPTH);
   assign empty      = (level == '0);
   assign head       = mem[rptr[FIFO_AW-1:0]];
   // rdy_q keeps s_ready low while reset is held and for the release cycle
   assign s.s_ready  = rdy_q & ~full & (state != STOP) & (state != RAMP_DN) &
                       ((state != IDLE) | enable);
   assign push       = s.s_valid & s.s_ready;

   function automatic logic [W-1:0] ramp_to(input logic [W-1:0] cur, input logic [W-1:0] tgt);
      if (cur < tgt) return ((tgt - cur) > STEP_W) ? cur + STEP_W : tgt;
      else           return ((cur - tgt) > STEP_W) ? cur - STEP_W : tgt;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wptr[FIFO_AW-1:0]] <= s.s_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         dac_val       <= IDLE_W;
         running       <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
         wptr          <= '0;
         rptr          <= '0;
         rdy_q         <= 1'b0;
      end else begin
         rdy_q     <= 1'b1;
         underflow <= 1'b0;
         if (push) wptr <= wptr + 1'b1;
         case (state)
            IDLE: begin
               if (enable) begin
                  state         <= PRIME;
                  underflow_cnt <= '0;
               end else begin
                  wptr <= '0;
                  rptr <= '0;
               end
            end
            PRIME: begin
               if (!enable) begin
                  state <= IDLE;
                  wptr  <= '0;
                  rptr  <= '0;
               end else if (val_req && level >= PRIME_L) begin
                  running <= 1'b1;
`ifdef DAC_RAMP_EN
                  if (ramp_to(dac_val, head) == head) begin
                     dac_val <= head;
                     rptr    <= rptr + 1'b1;
                     state   <= RUN;
                  end else begin
                     dac_val <= ramp_to(dac_val, head);
                     state   <= RAMP_UP;
                  end
`else
                  dac_val <= head;
                  rptr    <= rptr + 1'b1;
                  state   <= RUN;
`endif
               end
            end
            RUN: begin
               if (!enable) begin
`ifdef DAC_RAMP_EN
                  state <= RAMP_DN;
`else
                  state <= STOP;
`endif
               end else if (val_req) begin
                  if (!empty) begin
                     dac_val <= head;
                     rptr    <= rptr + 1'b1;
                  end else begin
                     underflow <= 1'b1;
                     if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (val_req) begin
                  dac_val <= IDLE_W;
                  wptr    <= '0;
                  rptr    <= '0;
                  running <= 1'b0;
                  state   <= IDLE;
               end
            end
            RAMP_UP: begin
               if (!enable) begin
                  state <= RAMP_DN;
               end else if (val_req) begin
                  if (ramp_to(dac_val, head) == head) begin
                     dac_val <= head;
                     rptr    <= rptr + 1'b1;
                     state   <= RUN;
                  end else begin
                     dac_val <= ramp_to(dac_val, head);
                  end
               end
            end
            RAMP_DN: begin
               if (val_req) begin
                  dac_val <= ramp_to(dac_val, IDLE_W);
                  if (ramp_to(dac_val, IDLE_W) == IDLE_W) begin
                     wptr    <= '0;
                     rptr    <= '0;
                     running <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
